// File: rtl/ma_controller_if.sv
// Request/answer handshake between the processor core and ma_controller.
interface ma_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              ma_request;
    logic [1:0]        ma_op;
    logic [ADDR_W-1:0] ma_where;
    logic [DATA_W-1:0] ma_what;
    logic [CNT_W-1:0]  ma_count;
    logic              ma_answer;
    logic [DATA_W-1:0] ma_result;
    logic              busy;

    modport master (
        output ma_request, ma_op, ma_where, ma_what, ma_count,
        input  ma_answer, ma_result, busy
    );
    modport slave (
        input  ma_request, ma_op, ma_where, ma_what, ma_count,
        output ma_answer, ma_result, busy
    );
endinterface

// File: rtl/ma_controller.sv
// Block memory-access sequencer: FILL / COPY / SUM over a word range on a single-port sync RAM.
// Optional debug read port enabled by defining MA_CTRL_DBG_PORT_EN.
module ma_controller #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    ma_controller_if.slave    ma,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MA_CTRL_DBG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_valid
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

    localparam logic [1:0] OP_FILL = 2'd0;
    localparam logic [1:0] OP_COPY = 2'd1;
    localparam logic [1:0] OP_RSVD = 2'd3;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] words_q, words_d;
    logic              answer_q, answer_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
`ifdef MA_CTRL_DBG_PORT_EN
    logic              dbg_rd_q, dbg_rd_d;
    logic              dbg_cap_q, dbg_cap_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
    logic              dbg_valid_q, dbg_valid_d;
`endif

    // Strobes/address are computed for the state being entered so every output is a flop.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        words_d     = words_q;
        answer_d    = answer_q;
        result_d    = result_q;
        busy_d      = busy_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ma.ma_request) begin
                    op_d    = ma.ma_op;
                    rem_d   = ma.ma_count;
                    acc_d   = '0;
                    words_d = '0;
                    if (ma.ma_op == OP_RSVD || ma.ma_count == '0) begin
                        state_d  = S_DONE;
                        answer_d = 1'b1;
                        result_d = (ma.ma_op == OP_RSVD) ? {DATA_W{1'b1}} : '0;
                    end else if (ma.ma_op == OP_FILL) begin
                        state_d     = S_WR;
                        busy_d      = 1'b1;
                        mem_addr_d  = ma.ma_where;
                        mem_wdata_d = ma.ma_what;
                        mem_we_d    = 1'b1;
                        dst_d       = ma.ma_where + ADDR_W'(1);
                    end else if (ma.ma_op == OP_COPY) begin
                        state_d    = S_RD;
                        busy_d     = 1'b1;
                        mem_addr_d = ma.ma_what[ADDR_W-1:0];
                        mem_re_d   = 1'b1;
                        src_d      = ma.ma_what[ADDR_W-1:0] + ADDR_W'(1);
                        dst_d      = ma.ma_where;
                    end else begin
                        state_d    = S_RD;
                        busy_d     = 1'b1;
                        mem_addr_d = ma.ma_where;
                        mem_re_d   = 1'b1;
                        src_d      = ma.ma_where + ADDR_W'(1);
                    end
                end
            end
            S_RD: state_d = S_WAIT;
            S_WAIT: begin
                if (op_q == OP_COPY) begin
                    state_d     = S_WR;
                    mem_addr_d  = dst_q;
                    mem_wdata_d = mem_rdata;
                    mem_we_d    = 1'b1;
                    dst_d       = dst_q + ADDR_W'(1);
                end else begin
                    acc_d = acc_q + mem_rdata;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d  = S_DONE;
                        answer_d = 1'b1;
                        busy_d   = 1'b0;
                        result_d = acc_q + mem_rdata;
                    end else begin
                        state_d    = S_RD;
                        mem_addr_d = src_q;
                        mem_re_d   = 1'b1;
                        src_d      = src_q + ADDR_W'(1);
                    end
                end
            end
            S_WR: begin
                rem_d   = rem_q - CNT_W'(1);
                words_d = words_q + DATA_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d  = S_DONE;
                    answer_d = 1'b1;
                    busy_d   = 1'b0;
                    result_d = words_q + DATA_W'(1);
                end else if (op_q == OP_FILL) begin
                    mem_addr_d = dst_q;
                    mem_we_d   = 1'b1;
                    dst_d      = dst_q + ADDR_W'(1);
                end else begin
                    state_d    = S_RD;
                    mem_addr_d = src_q;
                    mem_re_d   = 1'b1;
                    src_d      = src_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                if (!ma.ma_request) begin
                    state_d  = S_IDLE;
                    answer_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef MA_CTRL_DBG_PORT_EN
        // Staying idle means no request was taken, so the port is free for a debug read.
        dbg_rd_d    = 1'b0;
        dbg_cap_d   = dbg_rd_q;
        dbg_data_d  = dbg_data_q;
        dbg_valid_d = 1'b0;
        if (state_d == S_IDLE) begin
            mem_addr_d = dbg_addr;
            mem_re_d   = 1'b1;
            dbg_rd_d   = 1'b1;
        end
        if (dbg_cap_q && state_q == S_IDLE)
            dbg_data_d = mem_rdata;
        if (state_d == S_IDLE)
            dbg_valid_d = dbg_valid_q | (dbg_cap_q && state_q == S_IDLE);
`endif
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            words_q     <= '0;
            answer_q    <= 1'b0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
`ifdef MA_CTRL_DBG_PORT_EN
            dbg_rd_q    <= 1'b0;
            dbg_cap_q   <= 1'b0;
            dbg_data_q  <= '0;
            dbg_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            words_q     <= words_d;
            answer_q    <= answer_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
`ifdef MA_CTRL_DBG_PORT_EN
            dbg_rd_q    <= dbg_rd_d;
            dbg_cap_q   <= dbg_cap_d;
            dbg_data_q  <= dbg_data_d;
            dbg_valid_q <= dbg_valid_d;
`endif
        end
    end

    assign ma.ma_answer = answer_q;
    assign ma.ma_result = result_q;
    assign ma.busy      = busy_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_we       = mem_we_q;
    assign mem_re       = mem_re_q;
`ifdef MA_CTRL_DBG_PORT_EN
    assign dbg_data     = dbg_data_q;
    assign dbg_valid    = dbg_valid_q;
`endif

endmodule

// File: tb/tb_ma_controller.sv
// Directed bench for ma_controller: sync RAM model, result scoreboard, strobe counters.
module tb_ma_controller;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = '0, ld_data = '0;
    logic [15:0] mem [0:65535];
`ifdef MA_CTRL_DBG_PORT_EN
    logic [15:0] dbg_addr = '0;
    logic [15:0] dbg_data;
    logic        dbg_valid;
`endif

    int n_chk = 0, n_fail = 0;
    int we_cnt = 0, re_cnt = 0, busy_cnt = 0, both_cnt = 0;
    logic [15:0] sb [$];

    ma_controller_if #(.ADDR_W(16), .DATA_W(16), .CNT_W(16)) ma_if ();

    ma_controller #(.ADDR_W(16), .DATA_W(16), .CNT_W(16)) dut (
        .clk       (clk),
        .clr       (clr),
        .ma        (ma_if),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
`ifdef MA_CTRL_DBG_PORT_EN
        ,
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .dbg_valid (dbg_valid)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_re) re_cnt <= re_cnt + 1;
        if (ma_if.busy) busy_cnt <= busy_cnt + 1;
        if (mem_we && mem_re) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        ld_addr = a; ld_data = d; ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one request, wait for the answer, check latency/result/strobe counts, then release.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] where,
                          input logic [15:0] what, input logic [15:0] count, input logic [15:0] exp_res,
                          input int exp_lat, input int exp_we, input int exp_re, input int exp_busy,
                          input bit drop_early);
        int w0, r0, b0, lat;
        logic [15:0] e;
        w0 = we_cnt; r0 = re_cnt; b0 = busy_cnt; lat = 0;
        sb.push_back(exp_res);
        ma_if.ma_op = op; ma_if.ma_where = where; ma_if.ma_what = what; ma_if.ma_count = count;
        ma_if.ma_request = 1'b1;
        while (1) begin
            @(negedge clk);
            lat++;
            ma_if.ma_op = ~op; ma_if.ma_where = 16'hDEAD; ma_if.ma_what = 16'h0BAD; ma_if.ma_count = 16'h0007;
            if (drop_early) ma_if.ma_request = 1'b0;
            if (ma_if.ma_answer === 1'b1 || lat >= 200) break;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        e = sb.pop_front();
        chk({tag, "_result"}, ma_if.ma_result, e);
        chk({tag, "_we_cycles"}, we_cnt - w0, exp_we);
`ifndef MA_CTRL_DBG_PORT_EN
        chk({tag, "_re_cycles"}, re_cnt - r0, exp_re);
`endif
        chk({tag, "_busy_cycles"}, busy_cnt - b0, exp_busy);
        if (!drop_early) begin
            @(negedge clk);
            chk({tag, "_answer_hold"}, ma_if.ma_answer, 1'b1);
            chk({tag, "_result_hold"}, ma_if.ma_result, e);
            ma_if.ma_request = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_answer_fall"}, ma_if.ma_answer, 1'b0);
    endtask

    initial begin
        logic [15:0] acc_or;
        ma_if.ma_request = 1'b0; ma_if.ma_op = '0;
        ma_if.ma_where = '0; ma_if.ma_what = '0; ma_if.ma_count = '0;

        #3 clr = 1'b0;
        #1;
        chk("rst_answer", ma_if.ma_answer, 1'b0);
        chk("rst_result", ma_if.ma_result, 16'h0000);
        chk("rst_busy",   ma_if.busy, 1'b0);
        chk("rst_addr",   mem_addr, 16'h0000);
        chk("rst_wdata",  mem_wdata, 16'h0000);
        chk("rst_we",     mem_we, 1'b0);
        chk("rst_re",     mem_re, 1'b0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        load(16'h0014, 16'h1111);
        load(16'h0020, 16'h0001); load(16'h0021, 16'h0002); load(16'h0022, 16'h0003);
        for (int i = 0; i < 4; i++) load(16'h0040 + 16'(i), 16'h0000);
        load(16'hFFFE, 16'h8000); load(16'hFFFF, 16'h8001); load(16'h0000, 16'h0005);
        for (int i = 0; i < 8; i++) load(16'h0300 + 16'(i), 16'h0000);
        load(16'h0310, 16'h0000);

        run_op("fill", 2'd0, 16'h0010, 16'hBEEF, 16'd4, 16'h0004, 5, 4, 0, 4, 1'b0);
        for (int i = 0; i < 4; i++) chk($sformatf("fill_mem%0d", i), mem[16'h0010 + 16'(i)], 16'hBEEF);
        chk("fill_mem_after", mem[16'h0014], 16'h1111);

        run_op("copy", 2'd1, 16'h0040, 16'h0020, 16'd3, 16'h0003, 10, 3, 3, 9, 1'b0);
        for (int i = 0; i < 3; i++) chk($sformatf("copy_mem%0d", i), mem[16'h0040 + 16'(i)], 16'(i + 1));
        chk("copy_mem_after", mem[16'h0043], 16'h0000);

        run_op("sum", 2'd2, 16'hFFFE, 16'h0000, 16'd3, 16'h0006, 7, 0, 3, 6, 1'b1);
        run_op("cnt0", 2'd0, 16'h0050, 16'h1234, 16'd0, 16'h0000, 1, 0, 0, 0, 1'b0);
        run_op("op3",  2'd3, 16'h0050, 16'h1234, 16'd5, 16'hFFFF, 1, 0, 0, 0, 1'b0);

        // Abort a FILL of 8 in the middle of its second write.
        ma_if.ma_op = 2'd0; ma_if.ma_where = 16'h0300; ma_if.ma_what = 16'hA5A5; ma_if.ma_count = 16'd8;
        ma_if.ma_request = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("abort_answer", ma_if.ma_answer, 1'b0);
        chk("abort_busy",   ma_if.busy, 1'b0);
        chk("abort_result", ma_if.ma_result, 16'h0000);
        chk("abort_addr",   mem_addr, 16'h0000);
        chk("abort_wdata",  mem_wdata, 16'h0000);
        chk("abort_we",     mem_we, 1'b0);
        chk("abort_re",     mem_re, 1'b0);
        ma_if.ma_request = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("abort_first_word", mem[16'h0300], 16'hA5A5);
        acc_or = '0;
        for (int i = 2; i < 8; i++) acc_or = acc_or | mem[16'h0300 + 16'(i)];
        chk("abort_tail_untouched", acc_or, 16'h0000);
        run_op("post_rst", 2'd0, 16'h0310, 16'h7777, 16'd1, 16'h0001, 2, 1, 0, 1, 1'b0);
        chk("post_rst_mem", mem[16'h0310], 16'h7777);

`ifdef MA_CTRL_DBG_PORT_EN
        load(16'h0100, 16'h1234);
        dbg_addr = 16'h0100;
        repeat (4) @(negedge clk);
        chk("dbg_valid", dbg_valid, 1'b1);
        chk("dbg_data", dbg_data, 16'h1234);
        ma_if.ma_op = 2'd0; ma_if.ma_where = 16'h0400; ma_if.ma_what = 16'h0000; ma_if.ma_count = 16'd0;
        ma_if.ma_request = 1'b1;
        @(negedge clk);
        chk("dbg_valid_drop", dbg_valid, 1'b0);
        chk("dbg_data_hold", dbg_data, 16'h1234);
        ma_if.ma_request = 1'b0;
        repeat (2) @(negedge clk);
`endif

        chk("we_re_exclusive", both_cnt, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
